// File: rtl/usb_token_tx.sv
// usb_token_tx: host-side USB token/SOF transmitter that sends SYNC, PID/~PID, ADDR, ENDP, CRC5 and EOP, with bit stuffing and NRZI.
// Latency: start is accepted on the same edge (busy rises). The first SYNC symbol goes out on the next bit_en.
//   The packet takes 32 bit times plus stuff bits, then SE0, SE0, J; done pulses on the bit_en that ends the J.
// Backpressure: start is sampled only in IDLE. While busy it is ignored, and bit_en low freezes all line activity.
// Ports: clk, rst_n (async active-low), bit_en (bit-time strobe), start/pid/addr/endp (request),
//        busy/done (status), d_o ({D+,D-}), d_oe (transceiver enable).
// Optional: define USB_TOKEN_TX_CRC_INJECT_EN to add input crc_corrupt. It is sampled with start and inverts CRC5 field bit 0.
module usb_token_tx #(
  parameter bit USB_FULL_SPEED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
`ifdef USB_TOKEN_TX_CRC_INJECT_EN
  input  logic       crc_corrupt,
`endif
  output logic       busy,
  output logic       done,
  output logic [1:0] d_o,
  output logic       d_oe
);

  localparam logic [1:0] SYM_J   = USB_FULL_SPEED ? 2'b10 : 2'b01;
  localparam logic [1:0] SYM_K   = ~SYM_J;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  // Data states are consecutive so that a finished field advances with +1.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_PID   = 3'd2;
  localparam logic [2:0] ST_TOKEN = 3'd3;
  localparam logic [2:0] ST_CRC   = 3'd4;
  localparam logic [2:0] ST_SE0   = 3'd5;
  localparam logic [2:0] ST_EOPJ  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] tok_q, tok_d;
  logic [4:0]  crc_q, crc_d;
  logic [2:0]  ones_q, ones_d;
  logic        lvl_k_q, lvl_k_d;   // NRZI level: 1 = K, 0 = J
  logic [1:0]  d_q, d_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        inj_q;

`ifdef USB_TOKEN_TX_CRC_INJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      inj_q <= crc_corrupt;
    end
  end
`else
  assign inj_q = 1'b0;
`endif

  logic [7:0] pid_byte;
  logic [3:0] last_idx;
  logic       data_bit;
  logic       in_data;
  logic       stuff_now;

  assign pid_byte = {~pid_q, pid_q};
  assign in_data  = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                    (state_q == ST_TOKEN) || (state_q == ST_CRC);
  // A run of six 1s that ends on the last CRC bit is still stuffed, before SE0 starts.
  assign stuff_now = (ones_q == 3'd6) && (in_data || state_q == ST_SE0);

  always_comb begin
    data_bit = 1'b0;
    last_idx = 4'd7;
    case (state_q)
      ST_SYNC:  data_bit = (cnt_q == 4'd7);
      ST_PID:   data_bit = pid_byte[cnt_q[2:0]];
      ST_TOKEN: begin
        data_bit = tok_q[cnt_q];
        last_idx = 4'd10;
      end
      // The inverted remainder is sent MSB first, and field bit 0 is the injectable one.
      ST_CRC: begin
        data_bit = ~crc_q[4] ^ (inj_q && (cnt_q == 4'd0));
        last_idx = 4'd4;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pid_d   = pid_q;
    tok_d   = tok_q;
    crc_d   = crc_q;
    ones_d  = ones_q;
    lvl_k_d = lvl_k_q;
    d_d     = d_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        pid_d   = pid;
        tok_d   = {endp, addr};
        crc_d   = 5'h1f;
        cnt_d   = 4'd0;
        ones_d  = 3'd0;
        busy_d  = 1'b1;
        state_d = ST_SYNC;
      end
    end else if (bit_en) begin
      if (stuff_now) begin
        lvl_k_d = ~lvl_k_q;
        ones_d  = 3'd0;
        d_d     = lvl_k_d ? SYM_K : SYM_J;
        oe_d    = 1'b1;
      end else if (in_data) begin
        if (!data_bit) begin
          lvl_k_d = ~lvl_k_q;
        end
        ones_d = data_bit ? ones_q + 3'd1 : 3'd0;
        d_d    = lvl_k_d ? SYM_K : SYM_J;
        oe_d   = 1'b1;
        if (state_q == ST_TOKEN) begin
          crc_d = {crc_q[3:0], 1'b0} ^ ((data_bit ^ crc_q[4]) ? 5'h05 : 5'h00);
        end
        if (state_q == ST_CRC) begin
          crc_d = {crc_q[3:0], 1'b0};
        end
        if (cnt_q == last_idx) begin
          cnt_d   = 4'd0;
          state_d = state_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else if (state_q == ST_SE0) begin
        d_d = SYM_SE0;
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_EOPJ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        // EOP J: the first strobe drives J, and the second strobe ends it.
        if (cnt_q == 4'd0) begin
          d_d   = SYM_J;
          cnt_d = 4'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          oe_d    = 1'b0;
          d_d     = SYM_J;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ones_d  = 3'd0;
          lvl_k_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pid_q   <= 4'd0;
      tok_q   <= 11'd0;
      crc_q   <= 5'h1f;
      ones_q  <= 3'd0;
      lvl_k_q <= 1'b0;
      d_q     <= SYM_J;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pid_q   <= pid_d;
      tok_q   <= tok_d;
      crc_q   <= crc_d;
      ones_q  <= ones_d;
      lvl_k_q <= lvl_k_d;
      d_q     <= d_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d_o  = d_q;
  assign d_oe = oe_q;

endmodule
